// File: rtl/ff_state_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ff_state_pkg
//  Description : Shared definitions for the emulated flip-flop state bank:
//                host command encodings and the words-per-transfer helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ff_state_pkg;

  // Host command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  // Number of host words needed to cover n_ff state bits (ceiling division).
  function automatic int calc_words(input int n_ff, input int shift_w);
    return (n_ff + shift_w - 1) / shift_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ff_state_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : ff_state_rotator
//  Description : P-bit state register with a word pointer. Supports a
//                circular right-rotation by SHIFT_W (with a word inserted at
//                the top), a full parallel load, and a clear.
//  Ports       :
//    clk        in   clock
//    rst        in   synchronous active-high reset
//    clear      in   zero the state and the word pointer
//    rotate_en  in   rotate right by one word, rotate_in enters at the top
//    rotate_in  in   SHIFT_W word inserted by a rotation
//    load_en    in   parallel load of load_data (lowest priority)
//    load_data  in   P-bit value for a parallel load
//    state      out  current register contents
//    aligned    out  high when the word pointer is 0 (natural bit order)
//  Revision    : 1.0 - initial release
// ============================================================================
module ff_state_rotator #(
  parameter int N_FF    = 64,
  parameter int SHIFT_W = 32,
  parameter int W       = 2,
  parameter int P       = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               rotate_en,
  input  logic [SHIFT_W-1:0] rotate_in,
  input  logic               load_en,
  input  logic [P-1:0]       load_data,
  output logic [P-1:0]       state,
  output logic               aligned
);

  localparam int WPTR_W = (W > 1) ? $clog2(W) : 1;

  // Ones on the real flip-flop positions, zeros on the padding bits.
  localparam logic [P-1:0] KEEP_MASK = {P{1'b1}} >> (P - N_FF);

  logic [WPTR_W-1:0] wptr;
  logic [WPTR_W-1:0] wptr_inc;
  logic [P-1:0]      rot_raw;
  logic [P-1:0]      rot_word;

  // Word-wide right rotation; with a single word the incoming word is the
  // whole register.
  if (P > SHIFT_W) begin : g_rot_multi
    assign rot_raw = {rotate_in, state[P-1:SHIFT_W]};
  end else begin : g_rot_single
    assign rot_raw = rotate_in;
  end

  always_comb begin
    wptr_inc = wptr + 1'b1;
    if (wptr == WPTR_W'(W - 1)) begin
      wptr_inc = '0;
    end
    rot_word = rot_raw;
    // The rotation that completes a transfer sequence drops whatever landed
    // in the padding, so pad bits never leak into later reads.
    if (wptr_inc == '0) begin
      rot_word = rot_raw & KEEP_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      wptr  <= '0;
    end else if (clear) begin
      state <= '0;
      wptr  <= '0;
    end else if (rotate_en) begin
      state <= rot_word;
      wptr  <= wptr_inc;
    end else if (load_en) begin
      state <= load_data;
    end
  end

  assign aligned = (wptr == '0);

endmodule
`default_nettype wire

// File: rtl/ff_state_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ff_state_bank
//  Description : Emulated register bank that re-inserts the flip-flops cut
//                out of a netlist. Driven by the combinational core's D nets,
//                it feeds Q/QN back, and offers a host word interface that
//                reads/writes the full state by circular rotation.
//  Ports       :
//    CLK        in   sole clock
//    RST        in   synchronous active-high reset
//    comb_next  in   D inputs from the combinational core
//    ff_rstb    in   per-FF active-low clear
//    ff_q       out  emulated Q
//    ff_qn      out  emulated QN
//    run_en     in   one functional step (emulated clock edge) per cycle
//    cmd_valid  in   host command valid
//    cmd_ready  out  host command ready
//    cmd_op     in   NOP / READ / WRITE / CLEAR
//    cmd_wdata  in   WRITE payload
//    rsp_valid  out  READ response valid
//    rsp_ready  in   READ response ready
//    rsp_rdata  out  READ data
//    aligned    out  state in natural bit order
//  Revision    : 1.0 - initial release
// ============================================================================
module ff_state_bank
  import ff_state_pkg::*;
#(
  parameter int N_FF    = 64,
  parameter int SHIFT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_FF-1:0]    comb_next,
  input  logic [N_FF-1:0]    ff_rstb,
  output logic [N_FF-1:0]    ff_q,
  output logic [N_FF-1:0]    ff_qn,
  input  logic               run_en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [SHIFT_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [SHIFT_W-1:0] rsp_rdata,
  output logic               aligned
);

  localparam int W = calc_words(N_FF, SHIFT_W);
  localparam int P = W * SHIFT_W;

  cmd_op_e            op;
  logic               accept;
  logic               do_read;
  logic               do_write;
  logic               do_clear;
  logic               load_en;
  logic [SHIFT_W-1:0] rotate_in;
  logic [P-1:0]       load_data;
  logic [P-1:0]       state;
  logic               aligned_int;

  assign op        = cmd_op_e'(cmd_op);
  // Host commands and functional steps never share a cycle; a pending READ
  // response also blocks the next command.
  assign cmd_ready = !RST && !run_en && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign do_read   = accept && (op == OP_READ);
  assign do_write  = accept && (op == OP_WRITE);
  assign do_clear  = accept && (op == OP_CLEAR);

  // READ recirculates the bottom word; WRITE replaces it with the payload.
  assign rotate_in = do_write ? cmd_wdata : state[SHIFT_W-1:0];

  // Functional step and per-FF clear only act on a naturally ordered state.
  assign load_en = !accept && aligned_int;

  always_comb begin
    load_data = state;
    if (run_en) begin
      load_data[N_FF-1:0] = comb_next & ff_rstb;
    end else begin
      // Emulates the asynchronous clear, taking effect one edge late.
      load_data[N_FF-1:0] = state[N_FF-1:0] & ff_rstb;
    end
  end

  ff_state_rotator #(
    .N_FF    (N_FF),
    .SHIFT_W (SHIFT_W),
    .W       (W),
    .P       (P)
  ) u_rotator (
    .clk       (CLK),
    .rst       (RST),
    .clear     (do_clear),
    .rotate_en (do_read || do_write),
    .rotate_in (rotate_in),
    .load_en   (load_en),
    .load_data (load_data),
    .state     (state),
    .aligned   (aligned_int)
  );

  // Single outstanding READ response, held until the host takes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (do_read) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= state[SHIFT_W-1:0];
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign ff_q    = state[N_FF-1:0];
  assign ff_qn   = ~state[N_FF-1:0];
  assign aligned = aligned_int;

endmodule
`default_nettype wire

// File: tb/tb_ff_state_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ff_state_bank
//  Description : Directed self-checking bench for ff_state_bank with
//                N_FF=40, SHIFT_W=16 (3 words, 48-bit internal register).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_state_bank;

  localparam int N_FF    = 40;
  localparam int SHIFT_W = 16;
  localparam logic [39:0] ONES40 = 40'hFF_FFFF_FFFF;

  logic               clk;
  logic               RST;
  logic [N_FF-1:0]    comb_next;
  logic [N_FF-1:0]    ff_rstb;
  logic [N_FF-1:0]    ff_q;
  logic [N_FF-1:0]    ff_qn;
  logic               run_en;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [SHIFT_W-1:0] cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [SHIFT_W-1:0] rsp_rdata;
  logic               aligned;

  int n_cmp = 0;
  int n_err = 0;

  ff_state_bank #(.N_FF(N_FF), .SHIFT_W(SHIFT_W)) dut (
    .CLK       (clk),
    .RST       (RST),
    .comb_next (comb_next),
    .ff_rstb   (ff_rstb),
    .ff_q      (ff_q),
    .ff_qn     (ff_qn),
    .run_en    (run_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .aligned   (aligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_wdata = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic issue_clear();
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  // READ, capture the response, then complete the handshake.
  task automatic issue_read(output logic [15:0] data, output logic vld);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    data      = rsp_rdata;
    vld       = rsp_valid;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready);
    end
    step();
    RST = 1'b0;
    #1;
    n_cmp++;
    if (ff_q !== 40'h0) begin
      n_err++;
      $display("FAIL reset_ff_q: got %h want 0", ff_q);
    end
    n_cmp++;
    if (ff_qn !== ONES40) begin
      n_err++;
      $display("FAIL reset_ff_qn: got %h want %h", ff_qn, ONES40);
    end
    n_cmp++;
    if (aligned !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags: got aligned=%b rsp_valid=%b cmd_ready=%b want 1 0 1",
               aligned, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] exp_words [3];
    logic [15:0] d;
    logic        v;
    exp_words[0] = 16'h1111;
    exp_words[1] = 16'h2222;
    exp_words[2] = 16'h00AB;
    issue_write(exp_words[0]);
    n_cmp++;
    if (aligned !== 1'b0) begin
      n_err++;
      $display("FAIL write1_aligned: got %b want 0", aligned);
    end
    issue_write(exp_words[1]);
    issue_write(exp_words[2]);
    n_cmp++;
    if (ff_q !== 40'hAB_2222_1111 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL write3_state: got %h aligned=%b want ab22221111 aligned=1", ff_q, aligned);
    end
    for (int k = 0; k < 3; k++) begin
      issue_read(d, v);
      n_cmp++;
      if (d !== exp_words[k] || v !== 1'b1) begin
        n_err++;
        $display("FAIL read_word%0d: got %h valid=%b want %h valid=1", k, d, v, exp_words[k]);
      end
    end
    n_cmp++;
    if (ff_q !== 40'hAB_2222_1111 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL read_restore: got %h aligned=%b want ab22221111 aligned=1", ff_q, aligned);
    end
  endtask

  task automatic test_step();
    comb_next = 40'h12_3456_789A;
    ff_rstb   = ONES40 & ~40'h2;
    run_en    = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL step_cmd_ready: got %b want 0", cmd_ready);
    end
    step();
    run_en  = 1'b0;
    ff_rstb = ONES40;
    n_cmp++;
    if (ff_q !== 40'h12_3456_7898 || ff_qn !== ~40'h12_3456_7898) begin
      n_err++;
      $display("FAIL step_result: got q=%h qn=%h want q=1234567898", ff_q, ff_qn);
    end
    // Idle per-FF clear of bits 7:4.
    ff_rstb = ONES40 & ~40'hF0;
    step();
    ff_rstb = ONES40;
    n_cmp++;
    if (ff_q !== 40'h12_3456_7808) begin
      n_err++;
      $display("FAIL idle_rstb_clear: got %h want 1234567808", ff_q);
    end
  endtask

  task automatic test_blocked_step();
    issue_write(16'hAAAA);
    n_cmp++;
    if (ff_q !== 40'hAA_0012_3456 || aligned !== 1'b0) begin
      n_err++;
      $display("FAIL blocked_write1: got %h aligned=%b want aa00123456 aligned=0", ff_q, aligned);
    end
    // Step while misaligned, with a colliding command offered.
    comb_next = 40'h55_5555_5555;
    run_en    = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_wdata = 16'hDEAD;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL collide_cmd_ready: got %b want 0", cmd_ready);
    end
    step();
    step();
    run_en    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    // Per-FF clear while misaligned must be ignored too.
    ff_rstb = 40'h0;
    step();
    ff_rstb = ONES40;
    n_cmp++;
    if (ff_q !== 40'hAA_0012_3456 || aligned !== 1'b0) begin
      n_err++;
      $display("FAIL blocked_hold: got %h aligned=%b want aa00123456 aligned=0", ff_q, aligned);
    end
    issue_write(16'hBBBB);
    issue_write(16'hCCCC);
    n_cmp++;
    if (ff_q !== 40'hCC_BBBB_AAAA || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL blocked_finish: got %h aligned=%b want ccbbbbaaaa aligned=1", ff_q, aligned);
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] d;
    logic        v;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    step();
    cmd_op = 2'd2;
    cmd_wdata = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hAAAA || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_cycle%0d: got valid=%b data=%h ready=%b want 1 aaaa 0",
                 c, rsp_valid, rsp_rdata, cmd_ready);
      end
      step();
    end
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
    issue_read(d, v);
    n_cmp++;
    if (d !== 16'hBBBB) begin
      n_err++;
      $display("FAIL bp_read2: got %h want bbbb", d);
    end
    issue_read(d, v);
    n_cmp++;
    if (d !== 16'h00CC || ff_q !== 40'hCC_BBBB_AAAA || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL bp_read3: got %h q=%h aligned=%b want 00cc ccbbbbaaaa 1", d, ff_q, aligned);
    end
  endtask

  task automatic test_clear_reset();
    logic [15:0] d;
    logic        v;
    issue_write(16'h1234);
    issue_write(16'h5678);
    issue_clear();
    n_cmp++;
    if (ff_q !== 40'h0 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL clear_mid_seq: got %h aligned=%b want 0 aligned=1", ff_q, aligned);
    end
    // Leave a response pending, then reset.
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    RST       = 1'b1;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pending_rsp: got valid=%b aligned=%b want 0 1", rsp_valid, aligned);
    end
    RST = 1'b0;
    #1;
    // Padding: all-ones written into every word, pad bits must be dropped.
    issue_write(16'hFFFF);
    issue_write(16'hFFFF);
    issue_write(16'hFFFF);
    n_cmp++;
    if (ff_q !== ONES40 || ff_qn !== 40'h0) begin
      n_err++;
      $display("FAIL pad_write: got q=%h qn=%h want all-ones / 0", ff_q, ff_qn);
    end
    issue_read(d, v);
    issue_read(d, v);
    issue_read(d, v);
    n_cmp++;
    if (d !== 16'h00FF) begin
      n_err++;
      $display("FAIL pad_read: got %h want 00ff", d);
    end
  endtask

  initial begin
    RST       = 1'b1;
    comb_next = '0;
    ff_rstb   = ONES40;
    run_en    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_step();
    test_blocked_step();
    test_back_pressure();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
